// File: rtl/hdlc_tx_framer_pkg.sv
// hdlc_pkg: shared definitions for the HDLC transmit framer and the
// reusable CRC-16/X.25 engine.
//   - state_t          : framer FSM states
//   - HDLC_FLAG        : opening/closing flag octet
//   - HDLC_ABORT       : abort octet (a 0 followed by seven 1s, LSB first)
//   - FCS_POLY/FCS_INIT: reflected CRC-16/X.25 polynomial and seed
//   - STUFF_LIMIT      : run of 1s after which a 0 is inserted
//   - fcs16Step()      : one bit-serial CRC update
package hdlc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_FLAG,
    ST_DATA,
    ST_FCS,
    ST_END_FLAG,
    ST_ABORT
  } state_t;

  localparam logic [7:0]  HDLC_FLAG   = 8'h7E;
  localparam logic [7:0]  HDLC_ABORT  = 8'hFE;
  localparam logic [15:0] FCS_POLY    = 16'h8408;
  localparam logic [15:0] FCS_INIT    = 16'hFFFF;
  localparam logic [2:0]  STUFF_LIMIT = 3'd5;

  // Reflected CRC update: the register shifts towards bit 0 and the
  // polynomial is folded in whenever the outgoing bit differs from the data.
  function automatic logic [15:0] fcs16Step(input logic [15:0] crc, input logic dataBit);
    logic feedback;
    feedback  = crc[0] ^ dataBit;
    fcs16Step = {1'b0, crc[15:1]} ^ (feedback ? FCS_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/hdlc_tx_framer_if.sv
// hdlc_tx_framer_if: Tx-buffer handshake and serial line bundle.
//   Upstream -> framer : Tx_Enable, Tx_DataAvail, Tx_Data[7:0], Tx_AbortFrame
//   Framer -> upstream : Tx_RdBuff, Tx, Tx_Busy, Tx_Done, Tx_AbortedTrans
// master is the buffer/controller side, slave is the framer.
interface hdlc_tx_framer_if;

  logic       Tx_Enable;
  logic       Tx_DataAvail;
  logic [7:0] Tx_Data;
  logic       Tx_AbortFrame;
  logic       Tx_RdBuff;
  logic       Tx;
  logic       Tx_Busy;
  logic       Tx_Done;
  logic       Tx_AbortedTrans;

  modport master (
    output Tx_Enable, Tx_DataAvail, Tx_Data, Tx_AbortFrame,
    input  Tx_RdBuff, Tx, Tx_Busy, Tx_Done, Tx_AbortedTrans
  );

  modport slave (
    input  Tx_Enable, Tx_DataAvail, Tx_Data, Tx_AbortFrame,
    output Tx_RdBuff, Tx, Tx_Busy, Tx_Done, Tx_AbortedTrans
  );

endinterface

// File: rtl/hdlc_fcs16.sv
// hdlc_fcs16: bit-serial CRC-16/X.25 register, shared by Tx and Rx paths.
//   Clk, Rst : clock and asynchronous active-high reset (reset = FCS_INIT)
//   i_init   : reload FCS_INIT on the next edge
//   i_en     : fold i_bit into the CRC on the next edge (wins over i_init)
//   i_bit    : serial data bit
//   o_crc    : current CRC register (not complemented)
module hdlc_fcs16
  import hdlc_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  // An update takes priority so a caller may seed and feed in one place
  // without worrying about ordering; otherwise the register holds.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_crc <= FCS_INIT;
    end else if (i_en) begin
      r_crc <= fcs16Step(r_crc, i_bit);
    end else if (i_init) begin
      r_crc <= FCS_INIT;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer: bit-serial HDLC transmit framer.
//   Clk, Rst : clock (one line bit per cycle), async active-high reset
//   bus      : hdlc_tx_framer_if.slave
//              in : Tx_Enable, Tx_DataAvail, Tx_Data[7:0] (show-ahead), Tx_AbortFrame
//              out: Tx_RdBuff (pop strobe), Tx (serial, LSB first), Tx_Busy,
//                   Tx_Done, Tx_AbortedTrans
// Parameter FCS_EN (default 1) appends the complemented CRC-16/X.25 before
// the closing flag. Frame: flag, stuffed data, stuffed FCS, flag; the line
// idles at 1. An abort replaces the rest of the frame with 8'hFE.
module hdlc_tx_framer
  import hdlc_pkg::*;
#(
  parameter int FCS_EN = 1
)
(
  input  logic            Clk,
  input  logic            Rst,
  hdlc_tx_framer_if.slave bus
);

  state_t      r_state;
  logic [15:0] r_shift;
  logic [4:0]  r_bitCnt;
  logic [2:0]  r_ones;
  logic        r_tx;
  logic        r_rdPend;
  logic        r_rdBuff;
  logic        r_busy;
  logic        r_done;
  logic        r_aborted;

  logic        w_abortNow;
  logic        w_stuffNow;
  logic        w_boundary;
  logic        w_load;
  logic        w_crcEn;
  logic        w_crcInit;
  logic        w_crcBit;
  logic [15:0] w_crc;
  logic [15:0] w_fcsWord;
  logic [2:0]  w_onesInc;

  // r_bitCnt counts bits already placed on the line for the current octet
  // (or 16-bit FCS word), so a boundary is reached once the last bit is out.
  assign w_abortNow = bus.Tx_AbortFrame && (r_state != ST_IDLE) && (r_state != ST_ABORT);
  assign w_stuffNow = ((r_state == ST_DATA) || (r_state == ST_FCS)) && (r_ones == STUFF_LIMIT);
  assign w_boundary = (r_bitCnt == ((r_state == ST_FCS) ? 5'd16 : 5'd8));
  assign w_load     = !w_abortNow && !w_stuffNow && w_boundary && bus.Tx_DataAvail &&
                      ((r_state == ST_START_FLAG) || (r_state == ST_DATA));
  assign w_crcEn    = !w_abortNow &&
                      (w_load || ((r_state == ST_DATA) && !w_stuffNow && !w_boundary));
  assign w_crcBit   = w_load ? bus.Tx_Data[0] : r_shift[0];
  assign w_crcInit  = (r_state == ST_IDLE) || (r_state == ST_END_FLAG) || (r_state == ST_ABORT);
  assign w_fcsWord  = ~w_crc;
  assign w_onesInc  = r_ones + 3'd1;

  // The CRC sees exactly the unstuffed data bits, fed on the same edge that
  // drives each bit onto the line; it is reseeded outside the frame body.
  hdlc_fcs16 u_fcs16 (
    .Clk    (Clk),
    .Rst    (Rst),
    .i_init (w_crcInit),
    .i_en   (w_crcEn),
    .i_bit  (w_crcBit),
    .o_crc  (w_crc)
  );

  // Framer FSM. Every edge drives the next line bit into r_tx. A new octet's
  // bit 0 goes out on the edge that loads it, the remainder shifts from
  // r_shift. Abort is checked first so it beats byte load, end-of-data and
  // closing-flag completion. Inserted zeros hold r_shift and r_bitCnt, which
  // is what lets a stuffed octet simply take one more cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= 16'h0000;
      r_bitCnt  <= 5'd0;
      r_ones    <= 3'd0;
      r_tx      <= 1'b1;
      r_rdPend  <= 1'b0;
      r_rdBuff  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_rdBuff  <= r_rdPend;
      r_rdPend  <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (w_abortNow) begin
        r_state   <= ST_ABORT;
        r_busy    <= 1'b1;
        r_tx      <= HDLC_ABORT[0];
        r_shift   <= {9'd0, HDLC_ABORT[7:1]};
        r_bitCnt  <= 5'd1;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_tx     <= 1'b1;
            r_bitCnt <= 5'd0;
            if (bus.Tx_Enable && bus.Tx_DataAvail) begin
              r_state  <= ST_START_FLAG;
              r_busy   <= 1'b1;
              r_tx     <= HDLC_FLAG[0];
              r_shift  <= {9'd0, HDLC_FLAG[7:1]};
              r_bitCnt <= 5'd1;
              r_ones   <= 3'd0;
            end
          end
          ST_START_FLAG, ST_DATA: begin
            if (w_stuffNow) begin
              r_tx   <= 1'b0;
              r_ones <= 3'd0;
            end else if (w_boundary) begin
              if (bus.Tx_DataAvail) begin
                r_state  <= ST_DATA;
                r_tx     <= bus.Tx_Data[0];
                r_shift  <= {9'd0, bus.Tx_Data[7:1]};
                r_bitCnt <= 5'd1;
                r_ones   <= bus.Tx_Data[0] ? w_onesInc : 3'd0;
                r_rdPend <= 1'b1;
              end else if (FCS_EN != 0) begin
                r_state  <= ST_FCS;
                r_tx     <= w_fcsWord[0];
                r_shift  <= {1'b0, w_fcsWord[15:1]};
                r_bitCnt <= 5'd1;
                r_ones   <= w_fcsWord[0] ? w_onesInc : 3'd0;
              end else begin
                r_state  <= ST_END_FLAG;
                r_tx     <= HDLC_FLAG[0];
                r_shift  <= {9'd0, HDLC_FLAG[7:1]};
                r_bitCnt <= 5'd1;
              end
            end else begin
              r_tx     <= r_shift[0];
              r_shift  <= {1'b0, r_shift[15:1]};
              r_bitCnt <= r_bitCnt + 5'd1;
              r_ones   <= ((r_state == ST_DATA) && r_shift[0]) ? w_onesInc : 3'd0;
            end
          end
          ST_FCS: begin
            if (w_stuffNow) begin
              r_tx   <= 1'b0;
              r_ones <= 3'd0;
            end else if (w_boundary) begin
              r_state  <= ST_END_FLAG;
              r_tx     <= HDLC_FLAG[0];
              r_shift  <= {9'd0, HDLC_FLAG[7:1]};
              r_bitCnt <= 5'd1;
            end else begin
              r_tx     <= r_shift[0];
              r_shift  <= {1'b0, r_shift[15:1]};
              r_bitCnt <= r_bitCnt + 5'd1;
              r_ones   <= r_shift[0] ? w_onesInc : 3'd0;
            end
          end
          ST_END_FLAG, ST_ABORT: begin
            if (w_boundary) begin
              r_state  <= ST_IDLE;
              r_tx     <= 1'b1;
              r_busy   <= 1'b0;
              r_bitCnt <= 5'd0;
              r_done   <= (r_state == ST_END_FLAG);
            end else begin
              r_tx     <= r_shift[0];
              r_shift  <= {1'b0, r_shift[15:1]};
              r_bitCnt <= r_bitCnt + 5'd1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Tx              = r_tx;
  assign bus.Tx_RdBuff       = r_rdBuff;
  assign bus.Tx_Busy         = r_busy;
  assign bus.Tx_Done         = r_done;
  assign bus.Tx_AbortedTrans = r_aborted;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb_hdlc_tx_framer: directed bench for hdlc_tx_framer.
// dut0 has the FCS enabled and is fed from a small show-ahead byte queue;
// dut1 has no FCS and its single-byte buffer is driven directly.
module tb_hdlc_tx_framer;

  logic Clk;
  logic Rst;

  hdlc_tx_framer_if bus0 ();
  hdlc_tx_framer_if bus1 ();

  hdlc_tx_framer #(.FCS_EN(1)) dut0 (.Clk(Clk), .Rst(Rst), .bus(bus0));
  hdlc_tx_framer #(.FCS_EN(0)) dut1 (.Clk(Clk), .Rst(Rst), .bus(bus1));

  int         vectors     = 0;
  int         miscompares = 0;
  int         rdCnt;
  int         doneCnt;
  int         abCnt;
  int         firstRd;
  logic       timedOut;
  logic       oTx, oBusy, oRd, oDone, oAb;
  logic [7:0] q0[$];
  logic       capBits[$];
  logic       expBits[$];
  logic [7:0] digits[$];
  logic [7:0] payload[$];

  // Free-running clock, 10 time units per line bit.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Show-ahead Tx buffer for dut0: pops one byte per Tx_RdBuff pulse and
  // presents the new head a couple of time units after each edge.
  initial begin
    bus0.Tx_DataAvail = 1'b0;
    bus0.Tx_Data      = 8'h00;
    forever begin
      @(posedge Clk);
      #2;
      if (bus0.Tx_RdBuff === 1'b1 && q0.size() > 0) void'(q0.pop_front());
      bus0.Tx_DataAvail = (q0.size() != 0);
      bus0.Tx_Data      = (q0.size() != 0) ? q0[0] : 8'h00;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic sampleOutputs(input int sel);
    if (sel == 0) begin
      oTx = bus0.Tx; oBusy = bus0.Tx_Busy; oRd = bus0.Tx_RdBuff;
      oDone = bus0.Tx_Done; oAb = bus0.Tx_AbortedTrans;
    end else begin
      oTx = bus1.Tx; oBusy = bus1.Tx_Busy; oRd = bus1.Tx_RdBuff;
      oDone = bus1.Tx_Done; oAb = bus1.Tx_AbortedTrans;
    end
  endtask

  task automatic appendFlag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) expBits.push_back(f[i]);
  endtask

  // Reference line coding: LSB first, a 0 after every fifth consecutive 1.
  task automatic appendStuffed(input logic [7:0] bytesIn[$]);
    int   ones;
    logic b;
    ones = 0;
    foreach (bytesIn[k]) begin
      for (int i = 0; i < 8; i++) begin
        b = bytesIn[k][i];
        expBits.push_back(b);
        if (b) ones++; else ones = 0;
        if (ones == 5) begin
          expBits.push_back(1'b0);
          ones = 0;
        end
      end
    end
  endtask

  task automatic compareStream(input string tag);
    checkOutput({tag, " length"}, capBits.size(), expBits.size());
    for (int i = 0; i < capBits.size() && i < expBits.size(); i++)
      checkOutput($sformatf("%s bit%0d", tag, i), 32'(capBits[i]), 32'(expBits[i]));
  endtask

  // Pulses Tx_Enable for one cycle and records Tx for every busy cycle,
  // plus strobe counts, until the frame ends (bounded).
  task automatic applyStimulus(input int sel, input string tag);
    logic seen;
    logic fin;
    int   cyc;
    seen = 1'b0; fin = 1'b0; cyc = 0;
    capBits.delete();
    rdCnt = 0; doneCnt = 0; abCnt = 0; firstRd = -1;
    if (sel == 0) bus0.Tx_Enable = 1'b1; else bus1.Tx_Enable = 1'b1;
    step();
    if (sel == 0) bus0.Tx_Enable = 1'b0; else bus1.Tx_Enable = 1'b0;
    while (!fin && cyc < 2000) begin
      sampleOutputs(sel);
      if (oBusy) begin
        seen = 1'b1;
        capBits.push_back(oTx);
      end
      if (oRd) begin
        rdCnt++;
        if (firstRd < 0) firstRd = cyc;
        if (sel == 1) bus1.Tx_DataAvail = 1'b0;
      end
      if (oDone) doneCnt++;
      if (oAb) abCnt++;
      if (seen && !oBusy) fin = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
    timedOut = !fin;
    checkOutput({tag, " timeout"}, 32'(timedOut), 32'd0);
    repeat (3) begin
      step();
      sampleOutputs(sel);
      if (oDone) doneCnt++;
      if (oAb) abCnt++;
    end
  endtask

  initial begin
    int   ones;
    logic fin;
    int   cyc;

    Rst = 1'b1;
    bus0.Tx_Enable = 1'b0; bus0.Tx_AbortFrame = 1'b0;
    bus1.Tx_Enable = 1'b0; bus1.Tx_AbortFrame = 1'b0;
    bus1.Tx_DataAvail = 1'b0; bus1.Tx_Data = 8'h00;
    for (int i = 0; i < 9; i++) digits.push_back(8'h31 + 8'(i));

    // Reset values
    step(); step();
    sampleOutputs(0);
    checkOutput("reset Tx", 32'(oTx), 32'd1);
    checkOutput("reset Busy", 32'(oBusy), 32'd0);
    checkOutput("reset RdBuff", 32'(oRd), 32'd0);
    checkOutput("reset Done", 32'(oDone), 32'd0);
    checkOutput("reset Aborted", 32'(oAb), 32'd0);
    Rst = 1'b0;
    step();

    // "123456789" with FCS: check value 0x906E goes out as 6E, 90
    $display("[TB] frame 123456789 with FCS");
    foreach (digits[i]) q0.push_back(digits[i]);
    step(); step();
    applyStimulus(0, "x25");
    expBits.delete();
    payload = digits;
    payload.push_back(8'h6E);
    payload.push_back(8'h90);
    appendFlag(); appendStuffed(payload); appendFlag();
    compareStream("x25");
    checkOutput("x25 rdbuff pulses", rdCnt, 9);
    checkOutput("x25 first rdbuff cycle", firstRd, 9);
    checkOutput("x25 done pulses", doneCnt, 1);
    checkOutput("x25 abort pulses", abCnt, 0);

    // FCS disabled, byte 0xFF: 1,1,1,1,1,0,1,1,1 then flag, 25 cycles
    $display("[TB] single 0xFF without FCS");
    bus1.Tx_Data = 8'hFF;
    bus1.Tx_DataAvail = 1'b1;
    applyStimulus(1, "stuff");
    expBits.delete();
    payload.delete();
    payload.push_back(8'hFF);
    appendFlag(); appendStuffed(payload); appendFlag();
    compareStream("stuff");
    checkOutput("stuff frame cycles", capBits.size(), 25);
    checkOutput("stuff done pulses", doneCnt, 1);

    // Abort inside the third data byte
    $display("[TB] abort during third byte");
    q0.push_back(8'hAA); q0.push_back(8'hBB); q0.push_back(8'hCC); q0.push_back(8'hDD);
    step(); step();
    doneCnt = 0; abCnt = 0;
    bus0.Tx_Enable = 1'b1;
    step();
    bus0.Tx_Enable = 1'b0;
    for (int i = 0; i < 27; i++) begin
      sampleOutputs(0);
      if (oDone) doneCnt++;
      if (oAb) abCnt++;
      step();
    end
    bus0.Tx_AbortFrame = 1'b1;
    step();
    bus0.Tx_AbortFrame = 1'b0;
    q0.delete();
    sampleOutputs(0);
    checkOutput("abort bit0 Tx", 32'(oTx), 32'd0);
    checkOutput("abort pulse", 32'(oAb), 32'd1);
    if (oAb) abCnt++;
    ones = 0;
    for (int k = 1; k < 8; k++) begin
      step();
      sampleOutputs(0);
      if (oTx && oBusy) ones++;
      if (oAb) abCnt++;
      if (oDone) doneCnt++;
    end
    checkOutput("abort trailing ones", ones, 7);
    step();
    sampleOutputs(0);
    checkOutput("abort busy falls", 32'(oBusy), 32'd0);
    checkOutput("abort idle Tx", 32'(oTx), 32'd1);
    repeat (10) begin
      step();
      sampleOutputs(0);
      if (oAb) abCnt++;
      if (oDone) doneCnt++;
    end
    checkOutput("abort pulse count", abCnt, 1);
    checkOutput("abort no done", doneCnt, 0);

    // Abort in IDLE and enable with an empty buffer are both ignored
    $display("[TB] idle abort and empty-buffer enable");
    bus0.Tx_AbortFrame = 1'b1;
    bus0.Tx_Enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      sampleOutputs(0);
      checkOutput($sformatf("idle Tx c%0d", k), 32'(oTx), 32'd1);
      checkOutput($sformatf("idle Busy c%0d", k), 32'(oBusy), 32'd0);
      checkOutput($sformatf("idle Aborted c%0d", k), 32'(oAb), 32'd0);
    end
    bus0.Tx_AbortFrame = 1'b0;
    bus0.Tx_Enable = 1'b0;
    step();

    // Reset mid-data, then a clean frame must still carry the X.25 FCS
    $display("[TB] reset mid-frame");
    foreach (digits[i]) q0.push_back(digits[i]);
    step(); step();
    bus0.Tx_Enable = 1'b1;
    step();
    bus0.Tx_Enable = 1'b0;
    repeat (17) step();
    Rst = 1'b1;
    #1;
    sampleOutputs(0);
    checkOutput("midreset Tx", 32'(oTx), 32'd1);
    checkOutput("midreset Busy", 32'(oBusy), 32'd0);
    checkOutput("midreset RdBuff", 32'(oRd), 32'd0);
    checkOutput("midreset Done", 32'(oDone), 32'd0);
    checkOutput("midreset Aborted", 32'(oAb), 32'd0);
    q0.delete();
    step(); step();
    Rst = 1'b0;
    foreach (digits[i]) q0.push_back(digits[i]);
    step(); step();
    applyStimulus(0, "after reset");
    expBits.delete();
    payload = digits;
    payload.push_back(8'h6E);
    payload.push_back(8'h90);
    appendFlag(); appendStuffed(payload); appendFlag();
    compareStream("after reset");
    checkOutput("after reset done pulses", doneCnt, 1);

    // Back-to-back single-byte frames with Tx_Enable held high; 0xF8 ends
    // on five 1s, so a zero precedes the closing flag but none enter it.
    $display("[TB] back-to-back frames");
    capBits.delete();
    doneCnt = 0; rdCnt = 0; fin = 1'b0; cyc = 0;
    bus1.Tx_Data = 8'hF8;
    bus1.Tx_DataAvail = 1'b1;
    bus1.Tx_Enable = 1'b1;
    while (!fin && cyc < 400) begin
      step();
      cyc++;
      sampleOutputs(1);
      capBits.push_back(oTx);
      if (oRd) begin
        rdCnt++;
        bus1.Tx_DataAvail = 1'b0;
      end
      if (oDone) begin
        doneCnt++;
        if (doneCnt == 1) bus1.Tx_DataAvail = 1'b1;
        else fin = 1'b1;
      end
    end
    bus1.Tx_Enable = 1'b0;
    bus1.Tx_DataAvail = 1'b0;
    timedOut = !fin;
    checkOutput("b2b timeout", 32'(timedOut), 32'd0);
    expBits.delete();
    payload.delete();
    payload.push_back(8'hF8);
    appendFlag(); appendStuffed(payload); appendFlag();
    expBits.push_back(1'b1);
    appendFlag(); appendStuffed(payload); appendFlag();
    expBits.push_back(1'b1);
    compareStream("b2b");
    checkOutput("b2b rdbuff pulses", rdCnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hdlc_tx_framer.md
# hdlc_tx_framer

Bit-serial HDLC transmit framer for the Tx path of the HDLC controller. It pulls bytes from the Tx buffer and serialises each frame onto `Tx`: opening flag, data with zero insertion, optional CRC-16 FCS, closing flag. It also generates the abort pattern on request and drives the idle pattern (all ones) between frames. It is the transmitting end of the protocol whose receive side checks flags, abort, zero removal and idle.

## Interface
Parameters:
- `FCS_EN`, default 1: append the 16-bit FCS before the closing flag (0 = no FCS).

Ports:
- `Clk` in 1: system clock; one line bit per cycle.
- `Rst` in 1: reset, asynchronous, active-high.
- `Tx_Enable` in 1: request to start a frame; sampled only in IDLE.
- `Tx_DataAvail` in 1: Tx buffer holds at least one byte.
- `Tx_Data` in 8: head byte of the buffer (show-ahead); must be valid whenever `Tx_DataAvail`=1.
- `Tx_AbortFrame` in 1: abort the current frame.
- `Tx_RdBuff` out 1: one-cycle pop strobe for the byte just captured.
- `Tx` out 1: serial line, LSB first, registered.
- `Tx_Busy` out 1: high whenever state ≠ IDLE.
- `Tx_Done` out 1: one-cycle pulse after the last closing-flag bit.
- `Tx_AbortedTrans` out 1: one-cycle pulse when an abort is accepted.

## Operation
- Reset values: `Tx`=1, `Tx_RdBuff`=0, `Tx_Busy`=0, `Tx_Done`=0, `Tx_AbortedTrans`=0. State is IDLE, CRC register 16'hFFFF, ones counter 0, bit counter 0.
- States: IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT.
- IDLE: `Tx`=1. Move to START_FLAG when `Tx_Enable && Tx_DataAvail`. No frame starts on an empty buffer.
- START_FLAG: shifts 8'h7E with no stuffing, then goes to DATA. The ones counter is cleared.
- DATA, byte load:
  - At each byte boundary with `Tx_DataAvail`=1, capture `Tx_Data` on the edge that drives its bit 0, and pulse `Tx_RdBuff` in the following cycle.
  - At a boundary with `Tx_DataAvail`=0, go to FCS (or to END_FLAG if `FCS_EN`=0).
- Zero insertion (DATA and FCS only):
  - After five consecutive 1 bits on `Tx`, drive a 0 for one cycle. The shift register and CRC stall during that cycle, and the ones counter clears.
  - Any 0 bit clears the counter.
  - The counter carries across byte boundaries, and from DATA into FCS.
- FCS:
  - Algorithm is CRC-16/X.25: reflected polynomial 16'h8408, init 16'hFFFF, updated on each unstuffed data bit.
  - The transmitted FCS is ~crc, sent low byte first, LSB first, and stuffed.
- END_FLAG: shifts 8'h7E unstuffed. `Tx_Done` pulses the cycle after its last bit, then the block returns to IDLE. The CRC re-initialises to 16'hFFFF.
- Abort:
  - `Tx_AbortFrame`=1 in any state except IDLE/ABORT moves the block to ABORT. The current bit is abandoned, and `Tx_AbortedTrans` pulses for one cycle.
  - ABORT shifts 8'hFE LSB first (a 0 followed by seven 1s), unstuffed, then goes to IDLE.
  - Abort in IDLE or ABORT is ignored.
  - Buffer flushing is upstream's job.
- Simultaneous events:
  - Abort wins over byte load, end-of-data and end-flag completion.
  - `Tx_Enable` held high gives back-to-back frames separated by at least one idle `Tx`=1 cycle.
- Reset mid-frame forces all outputs to reset values immediately; no partial flag or abort is emitted.

## Timing
- Start condition sampled at edge N → `Tx`=0 (flag bit 0) in cycle N+1; flag occupies cycles N+1..N+8.
- First data bit appears in cycle N+9, and `Tx_RdBuff` is high in cycle N+10.
- Frame length with no stuffing: 8 + 8·n + 16·FCS_EN + 8 cycles. Each inserted zero adds one cycle.
- Abort sampled at edge M → abort bit 0 on `Tx` in cycle M+1, `Tx_AbortedTrans` high in cycle M+1, `Tx`=1 again from cycle M+9.
- `Tx_Done` is high in the first IDLE cycle after the closing flag.
- Upstream must update `Tx_Data`/`Tx_DataAvail` within 7 cycles after `Tx_RdBuff`.

## Structure
- `hdlc_pkg`: state enum, `HDLC_FLAG`=8'h7E, `HDLC_ABORT`=8'hFE, `FCS_POLY`=16'h8408, `FCS_INIT`=16'hFFFF, `STUFF_LIMIT`=5.
- Sub-module `hdlc_fcs16`: bit-serial CRC with `init`, `en` and `bit` inputs and a 16-bit CRC output. The same module is reusable on the Rx side for checking.

## Test plan
- `FCS_EN`=1, bytes 0x31..0x39 ("123456789") → line shows 7E, the nine bytes LSB first, then FCS bytes 0x6E, 0x90, then 7E. `Tx_RdBuff` gives 9 pulses and `Tx_Done` gives 1 pulse.
- `FCS_EN`=0, single byte 0xFF → after the flag, `Tx` reads 1,1,1,1,1,0,1,1,1 (9 cycles), then 7E. The inserted 0 stalls the byte, and frame length is 25 cycles.
- Abort asserted during the third data byte → next cycle `Tx`=0 followed by seven 1s, `Tx_AbortedTrans` pulses once, `Tx_Done` never pulses, and `Tx_Busy` falls after the eighth abort bit.
- `Tx_AbortFrame` pulsed in IDLE, and `Tx_Enable` with `Tx_DataAvail`=0 → `Tx` stays 1, `Tx_Busy` stays 0, no `Tx_AbortedTrans`.
- `Rst` pulsed while mid-data → `Tx`=1 and all strobes 0 within the same cycle. The next frame's FCS still matches the X.25 value, confirming the CRC re-initialised.
- `Tx_Enable` held high over two single-byte frames → exactly one or more `Tx`=1 cycles between the closing and opening flags, and stuffing never occurs inside the flags.
